// File: rtl/m_rf_scoreboard.sv
// ---------------------------------------------------------------------------
// m_rf_scoreboard
// Multi-port integer register file for the dual-issue pipeline: NR
// combinational read ports with same-cycle write bypass, two synchronous
// write ports (port 1 is the younger instruction and wins conflicts), a
// per-register busy scoreboard, a sticky halt flag and a retired-write counter.
//
// Ports
//   w_clk            clock, all state updates on the rising edge
//   w_rst_n          asynchronous active-low reset
//   w_ra   [NR*AW]   read addresses, port i at [i*AW +: AW]
//   w_rd   [NR*XLEN] read data, port i at [i*XLEN +: XLEN]
//   w_rbusy[NR]      operand of read port i not yet produced
//   w_we0/1, w_wa0/1, w_wd0/1   writeback ports
//   w_rsv, w_rsv_a   decode reservation of a destination register
//   w_halt           sticky flag, set by any write to HALT_REG
//   w_wcnt [32]      number of retired register writes (wraps)
//
// WCNT_RST is the reset value of the write counter. It is 0 in the
// pipeline; a nonzero value lets a short run exercise counter wrap.
// ---------------------------------------------------------------------------
module m_rf_scoreboard #(
    parameter int          XLEN     = 32,
    parameter int          NREG     = 32,
    parameter int          AW       = 5,
    parameter int          NR       = 4,
    parameter int          HALT_REG = 30,
    parameter logic [31:0] WCNT_RST = 32'd0
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    input  logic [NR*AW-1:0]     w_ra,
    output logic [NR*XLEN-1:0]   w_rd,
    output logic [NR-1:0]        w_rbusy,
    input  logic                 w_we0,
    input  logic                 w_we1,
    input  logic [AW-1:0]        w_wa0,
    input  logic [AW-1:0]        w_wa1,
    input  logic [XLEN-1:0]      w_wd0,
    input  logic [XLEN-1:0]      w_wd1,
    input  logic                 w_rsv,
    input  logic [AW-1:0]        w_rsv_a,
    output logic                 w_halt,
    output logic [31:0]          w_wcnt
);

    localparam logic [AW-1:0] HALT_A = AW'(HALT_REG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            halt_q;
    logic            halt_d;
    logic [31:0]     wcnt_q;
    logic [31:0]     wcnt_d;

    // Writes that actually retire (address 0 is discarded).
    logic wr0_s;
    logic wr1_s;
    assign wr0_s = w_we0 && (w_wa0 != '0);
    assign wr1_s = w_we1 && (w_wa1 != '0);

    // Next state of array, scoreboard, halt flag and write counter.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        busy_d[0] = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            // Port 0 first so that port 1 overrides on an address clash.
            if (wr0_s && (w_wa0 == AW'(r))) begin
                regs_d[r] = w_wd0;
            end else begin
                regs_d[r] = regs_q[r];
            end
            if (wr1_s && (w_wa1 == AW'(r))) begin
                regs_d[r] = w_wd1;
            end else begin
                regs_d[r] = regs_d[r];
            end
            // A reserve wins over a clear: a new producer is now in flight.
            if (w_rsv && (w_rsv_a == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((wr0_s && (w_wa0 == AW'(r))) || (wr1_s && (w_wa1 == AW'(r)))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
        halt_d = halt_q
               | (w_we0 && (w_wa0 == HALT_A))
               | (w_we1 && (w_wa1 == HALT_A));
        wcnt_d = wcnt_q + 32'(wr0_s) + 32'(wr1_s);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
            halt_q <= 1'b0;
            wcnt_q <= WCNT_RST;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
            halt_q <= halt_d;
            wcnt_q <= wcnt_d;
        end
    end

    // Read ports: zero register, then younger bypass, older bypass, array.
    // Outputs are forced to zero while reset is held so that a bypassed
    // write presented during reset never leaks out.
    always_comb begin
        w_rd    = '0;
        w_rbusy = '0;
        for (int i = 0; i < NR; i++) begin
            logic [AW-1:0] ra_s;
            logic          hit0_s;
            logic          hit1_s;
            ra_s   = w_ra[i*AW +: AW];
            hit0_s = w_we0 && (w_wa0 == ra_s);
            hit1_s = w_we1 && (w_wa1 == ra_s);
            if (!w_rst_n || (ra_s == '0)) begin
                w_rd[i*XLEN +: XLEN] = '0;
                w_rbusy[i]           = 1'b0;
            end else begin
                if (hit1_s) begin
                    w_rd[i*XLEN +: XLEN] = w_wd1;
                end else if (hit0_s) begin
                    w_rd[i*XLEN +: XLEN] = w_wd0;
                end else begin
                    w_rd[i*XLEN +: XLEN] = regs_q[ra_s];
                end
                // Bypassed data counts as valid.
                w_rbusy[i] = busy_q[ra_s] && !(hit0_s || hit1_s);
            end
        end
    end

    assign w_halt = halt_q;
    assign w_wcnt = wcnt_q;

endmodule

// File: tb/tb_m_rf_scoreboard.sv
// ---------------------------------------------------------------------------
// Bench for m_rf_scoreboard. A stimulus process drives each cycle, predicts
// the outputs from a reference model and queues the prediction; a monitor
// pops and compares on every falling edge. A second instance with the write
// counter starting at 0xFFFFFFFF shares the inputs to cover counter wrap.
// ---------------------------------------------------------------------------
module tb_m_rf_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NR   = 4;
    localparam int HREG = 30;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*AW-1:0]  ra;
    logic [NR*XLEN-1:0] rd, rd2;
    logic [NR-1:0]     rbusy, rbusy2;
    logic              we0, we1, rsv;
    logic [AW-1:0]     wa0, wa1, rsv_a;
    logic [XLEN-1:0]   wd0, wd1;
    logic              halt, halt2;
    logic [31:0]       wcnt, wcnt2;

    always #5 clk = ~clk;

    m_rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NR(NR), .HALT_REG(HREG)) u_dut (
        .w_clk(clk), .w_rst_n(rst_n), .w_ra(ra), .w_rd(rd), .w_rbusy(rbusy),
        .w_we0(we0), .w_we1(we1), .w_wa0(wa0), .w_wa1(wa1), .w_wd0(wd0), .w_wd1(wd1),
        .w_rsv(rsv), .w_rsv_a(rsv_a), .w_halt(halt), .w_wcnt(wcnt)
    );

    m_rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NR(NR), .HALT_REG(HREG),
                      .WCNT_RST(32'hFFFF_FFFF)) u_wrap (
        .w_clk(clk), .w_rst_n(rst_n), .w_ra(ra), .w_rd(rd2), .w_rbusy(rbusy2),
        .w_we0(we0), .w_we1(we1), .w_wa0(wa0), .w_wa1(wa1), .w_wd0(wd0), .w_wd1(wd1),
        .w_rsv(rsv), .w_rsv_a(rsv_a), .w_halt(halt2), .w_wcnt(wcnt2)
    );

    typedef struct {
        logic [XLEN-1:0] rd [NR];
        logic [NR-1:0]   rbusy;
        logic            halt;
        logic [31:0]     wcnt;
        logic [31:0]     wcnt2;
    } exp_t;

    exp_t q[$];

    // Reference model: architectural state as plain arrays.
    logic [XLEN-1:0] mem [NREG];
    bit              mbusy [NREG];
    bit              m_halt;
    int unsigned     m_wcnt;

    int checks   = 0;
    int failures = 0;

    function automatic void model_reset();
        for (int r = 0; r < NREG; r++) begin
            mem[r]   = '0;
            mbusy[r] = 1'b0;
        end
        m_halt = 1'b0;
        m_wcnt = 0;
    endfunction

    function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we1 && a == wa1) return wd1;
        if (we0 && a == wa0) return wd0;
        return mem[a];
    endfunction

    // Prediction for the inputs currently applied.
    function automatic void push_expected();
        exp_t e;
        for (int i = 0; i < NR; i++) begin
            logic [AW-1:0] a;
            a = ra[i*AW +: AW];
            if (!rst_n) begin
                e.rd[i]    = '0;
                e.rbusy[i] = 1'b0;
            end else begin
                e.rd[i]    = model_read(a);
                e.rbusy[i] = (a != 0) && mbusy[a] && !((we0 && wa0 == a) || (we1 && wa1 == a));
            end
        end
        e.halt  = m_halt;
        e.wcnt  = m_wcnt;
        e.wcnt2 = m_wcnt + 32'hFFFF_FFFF;
        q.push_back(e);
    endfunction

    // Apply one rising edge to the model.
    function automatic void model_commit();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (we0 && wa0 == HREG) m_halt = 1'b1;
            if (we1 && wa1 == HREG) m_halt = 1'b1;
            for (int r = 1; r < NREG; r++) begin
                bit wr;
                wr = (we0 && wa0 == r) || (we1 && wa1 == r);
                if (rsv && rsv_a == r) mbusy[r] = 1'b1;
                else if (wr)           mbusy[r] = 1'b0;
            end
            if (we0 && wa0 != 0) begin mem[wa0] = wd0; m_wcnt = m_wcnt + 1; end
            if (we1 && wa1 != 0) begin mem[wa1] = wd1; m_wcnt = m_wcnt + 1; end
        end
    endfunction

    task automatic drive(input logic e0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                         input logic e1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                         input logic rv, input logic [AW-1:0] rva, input logic [NR*AW-1:0] rav);
        we0 = e0; wa0 = a0; wd0 = d0;
        we1 = e1; wa1 = a1; wd1 = d1;
        rsv = rv; rsv_a = rva; ra = rav;
        push_expected();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle(input logic [NR*AW-1:0] rav);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, rav);
    endtask

    function automatic logic [NR*AW-1:0] ra_all(input logic [AW-1:0] a);
        return {NR{a}};
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: compare the queued prediction on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                for (int i = 0; i < NR; i++) begin
                    chk($sformatf("rd[%0d]", i), rd[i*XLEN +: XLEN], e.rd[i]);
                end
                chk("rbusy", 32'(rbusy), 32'(e.rbusy));
                chk("halt",  32'(halt),  32'(e.halt));
                chk("wcnt",  wcnt,  e.wcnt);
                chk("wcnt_wrap", wcnt2, e.wcnt2);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        rsv = 1'b0; rsv_a = '0; ra = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Held in reset: writes bypass nothing, everything reads 0.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd6, 32'h1111_2222, 1'b1, 5'd5, {5'd6, 5'd5, 5'd6, 5'd5});
        idle(ra_all(5'd5));
        rst_n = 1'b1;
        idle({5'd3, 5'd2, 5'd1, 5'd0});

        // Basic write then read on all ports.
        drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra_all(5'd0));
        idle(ra_all(5'd5));

        // Same-address dual write: port 1 wins, counts twice.
        drive(1'b1, 5'd7, 32'h0000_AAAA, 1'b1, 5'd7, 32'h0000_BBBB, 1'b0, 5'd0, {5'd5, 5'd0, 5'd7, 5'd7});
        idle(ra_all(5'd7));

        // Zero register ignores writes and reservations.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, ra_all(5'd0));
        idle(ra_all(5'd0));

        // Scoreboard: reserve, clear by write, reserve beats clear.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, ra_all(5'd3));
        idle(ra_all(5'd3));
        drive(1'b1, 5'd3, 32'h0000_0009, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra_all(5'd3));
        idle(ra_all(5'd3));
        drive(1'b1, 5'd3, 32'h0000_0005, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, ra_all(5'd3));
        idle(ra_all(5'd3));

        // Halt: set by port-1 write, sticky across further writes.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'd1, 1'b0, 5'd0, ra_all(5'd30));
        idle(ra_all(5'd30));
        drive(1'b1, 5'd4, 32'h0000_0044, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra_all(5'd4));
        idle(ra_all(5'd4));

        // Asynchronous reset mid-cycle with writes pending.
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h9999_9999;
        we1 = 1'b1; wa1 = 5'd30; wd1 = 32'h3030_3030;
        rsv = 1'b1; rsv_a = 5'd11; ra = ra_all(5'd5);
        #2;
        rst_n = 1'b0;
        model_reset();
        push_expected();
        @(posedge clk);
        model_commit();
        #1;
        rst_n = 1'b1;
        idle({5'd11, 5'd9, 5'd7, 5'd5});

        // Randomised traffic over a small address window plus the halt register.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0]    a0, a1, rva;
            logic [NR*AW-1:0] rav;
            a0  = ($urandom_range(0, 9) == 0) ? 5'(HREG) : 5'($urandom_range(0, 7));
            a1  = ($urandom_range(0, 9) == 0) ? 5'(HREG) : 5'($urandom_range(0, 7));
            rva = 5'($urandom_range(0, 7));
            for (int i = 0; i < NR; i++) begin
                rav[i*AW +: AW] = 5'($urandom_range(0, 7));
            end
            drive(1'($urandom_range(0, 1)), a0, 32'($urandom),
                  1'($urandom_range(0, 1)), a1, 32'($urandom),
                  1'($urandom_range(0, 3) == 0), rva, rav);
        end
        idle(ra_all(5'd1));

        // Let the monitor drain, bounded.
        for (int w = 0; w < 8 && q.size() > 0; w++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 predictions left", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
